// File: rtl/token_ctrl_pkg.sv
// ============================================================================
// token_ctrl_pkg : state encoding and width helpers for token_time_controller
// Revision: 1.0
// ============================================================================
`default_nettype none

package token_ctrl_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_AUTH    = 2'd1;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;
  localparam logic [1:0] ST_LOCKOUT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_AUTH    = ST_AUTH,
    S_ACTIVE  = ST_ACTIVE,
    S_LOCKOUT = ST_LOCKOUT
  } state_e;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/token_time_controller_down_counter.sv
// ============================================================================
// down_counter : loadable down counter that saturates at zero
// Revision: 1.0
// ============================================================================
`default_nettype none

module down_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/token_time_controller.sv
// ============================================================================
// token_time_controller : token-authenticated, time-limited one-hot channel grant
// Revision: 1.0
// ============================================================================
`default_nettype none

module token_time_controller
  import token_ctrl_pkg::*;
#(
  parameter int TOKEN_W     = 3,
  parameter int DATA_W      = 8,
  parameter int NUM_CH      = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 16,
  parameter int CONFIRM_TO  = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           request_i,
  input  logic [$clog2(NUM_CH)-1:0]      ch_sel_i,
  input  logic [TOKEN_W-1:0]             system_token_i,
  input  logic [DATA_W-1:0]              time_data_i,
  input  logic                           confirm_i,
  input  logic [TOKEN_W-1:0]             user_token_i,
  output logic [NUM_CH-1:0]              grant_o,
  output logic [DATA_W-1:0]              data_q_o,
  output logic [DATA_W-1:0]              data_p_o,
  output logic                           busy_o,
  output logic                           locked_o,
  output logic                           err_o,
  output logic                           done_o,
  output logic [cnt_width(MAX_TRIES)-1:0] fail_cnt_o
);

  localparam int CH_W   = $clog2(NUM_CH);
  localparam int FC_W   = cnt_width(MAX_TRIES);
  localparam int LOCK_W = cnt_width(LOCK_CYCLES);
  localparam int TO_W   = cnt_width(CONFIRM_TO);

  state_e              state_q;
  logic [CH_W-1:0]     ch_q;
  logic [TOKEN_W-1:0]  token_q;
  logic [DATA_W-1:0]   time_q;
  logic [NUM_CH-1:0]   grant_q;
  logic [DATA_W-1:0]   data_p_q;
  logic                busy_q, locked_q, err_q, done_q;
  logic [FC_W-1:0]     fail_cnt_q;

  logic                req_ok, match, last_try;
  logic                gnt_load, gnt_en, gnt_zero;
  logic                lock_load, lock_en, lock_zero;
  logic                to_load, to_en, to_zero;
  logic [DATA_W-1:0]   gnt_cnt;
  logic [LOCK_W-1:0]   lock_cnt;
  logic [TO_W-1:0]     to_cnt;

  assign req_ok   = request_i && (time_data_i != '0) && (int'(ch_sel_i) < NUM_CH);
  assign match    = (user_token_i == token_q);
  assign last_try = (int'(fail_cnt_q) + 1) >= MAX_TRIES;

  always_comb begin
    to_load   = (state_q == S_IDLE) && req_ok;
    to_en     = (state_q == S_AUTH) && !confirm_i && !to_zero;
    gnt_load  = (state_q == S_AUTH) && confirm_i && match;
    gnt_en    = (state_q == S_ACTIVE) && !gnt_zero;
    lock_load = (state_q == S_AUTH) && confirm_i && !match && last_try;
    lock_en   = (state_q == S_LOCKOUT) && !lock_zero;
  end

  // The grant timer doubles as the visible remaining-time output.
  down_counter #(.W(DATA_W)) u_grant_timer (
    .clk_i(clk_i), .rst_ni(rst_ni), .load_i(gnt_load), .load_val_i(time_q),
    .en_i(gnt_en), .cnt_o(gnt_cnt), .zero_o(gnt_zero)
  );

  down_counter #(.W(LOCK_W)) u_lock_timer (
    .clk_i(clk_i), .rst_ni(rst_ni), .load_i(lock_load), .load_val_i(LOCK_W'(LOCK_CYCLES)),
    .en_i(lock_en), .cnt_o(lock_cnt), .zero_o(lock_zero)
  );

  down_counter #(.W(TO_W)) u_confirm_timer (
    .clk_i(clk_i), .rst_ni(rst_ni), .load_i(to_load), .load_val_i(TO_W'(CONFIRM_TO)),
    .en_i(to_en), .cnt_o(to_cnt), .zero_o(to_zero)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      token_q    <= '0;
      time_q     <= '0;
      grant_q    <= '0;
      data_p_q   <= '0;
      busy_q     <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      fail_cnt_q <= '0;
    end else begin
      err_q  <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req_ok) begin
            ch_q    <= ch_sel_i;
            token_q <= system_token_i;
            time_q  <= time_data_i;
            busy_q  <= 1'b1;
            state_q <= S_AUTH;
          end else if (request_i) begin
            err_q <= 1'b1;
          end
        end
        S_AUTH: begin
          if (confirm_i && match) begin
            grant_q    <= NUM_CH'(1) << ch_q;
            data_p_q   <= time_q;
            fail_cnt_q <= '0;
            state_q    <= S_ACTIVE;
          end else if (confirm_i && last_try) begin
            fail_cnt_q <= FC_W'(MAX_TRIES);
            err_q      <= 1'b1;
            locked_q   <= 1'b1;
            state_q    <= S_LOCKOUT;
          end else if (confirm_i) begin
            fail_cnt_q <= fail_cnt_q + FC_W'(1);
            err_q      <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end else if (to_cnt == TO_W'(1)) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_ACTIVE: begin
          if (gnt_cnt == DATA_W'(1)) begin
            grant_q <= '0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_LOCKOUT: begin
          if (lock_cnt == LOCK_W'(1)) begin
            locked_q   <= 1'b0;
            fail_cnt_q <= '0;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant_o    = grant_q;
  assign data_q_o   = gnt_cnt;
  assign data_p_o   = data_p_q;
  assign busy_o     = busy_q;
  assign locked_o   = locked_q;
  assign err_o      = err_q;
  assign done_o     = done_q;
  assign fail_cnt_o = fail_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_token_time_controller.sv
// ============================================================================
// tb_token_time_controller : self-checking bench for token_time_controller
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_token_time_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       request = 1'b0;
  logic       confirm = 1'b0;
  logic [1:0] ch_sel = '0;
  logic [2:0] system_token = '0;
  logic [2:0] user_token = '0;
  logic [7:0] time_data = '0;
  logic [3:0] grant;
  logic [7:0] data_q, data_p;
  logic       busy, locked, err, done;
  logic [1:0] fail_cnt;

  int checks = 0;
  int errors = 0;
  int model_fail = 0;

  typedef struct {
    bit         is_grant;
    logic [3:0] grant;
    int         dur;
  } exp_t;

  typedef struct {
    logic [2:0] tok;
    logic [1:0] ch;
    logic [7:0] t;
    logic [2:0] ut;
  } vec_t;

  exp_t sb[$];
  vec_t vec[7];

  always #5 clk = ~clk;

  token_time_controller dut (
    .clk_i(clk), .rst_ni(rst_n), .request_i(request), .ch_sel_i(ch_sel),
    .system_token_i(system_token), .time_data_i(time_data), .confirm_i(confirm),
    .user_token_i(user_token), .grant_o(grant), .data_q_o(data_q), .data_p_o(data_p),
    .busy_o(busy), .locked_o(locked), .err_o(err), .done_o(done), .fail_cnt_o(fail_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT reports err or starts a grant.
  exp_t cur;
  int   gcnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      gcnt = 0;
    end else begin
      chk("err_done_exclusive", {31'd0, err & done}, 32'd0);
      if (err) begin
        chk("sb_nonempty_on_err", {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) begin
          cur = sb.pop_front();
          chk("expected_err", {31'd0, cur.is_grant}, 32'd0);
        end
      end
      if (grant != '0) begin
        if (gcnt == 0) begin
          chk("sb_nonempty_on_grant", {31'd0, sb.size() > 0}, 32'd1);
          if (sb.size() > 0) cur = sb.pop_front();
          chk("expected_grant", {31'd0, cur.is_grant}, 32'd1);
          chk("data_p_at_grant", data_p, cur.dur);
        end
        chk("grant_vec", grant, cur.grant);
        chk("data_q", data_q, cur.dur - gcnt);
        gcnt++;
      end
      if (done) begin
        chk("grant_len", gcnt, cur.dur);
        chk("data_q_done", data_q, 0);
        chk("data_p_done", data_p, cur.dur);
        gcnt = 0;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_err();
    exp_t e;
    e.is_grant = 1'b0; e.grant = '0; e.dur = 0;
    sb.push_back(e);
  endtask

  task automatic push_grant(input logic [1:0] ch, input int dur);
    exp_t e;
    logic [3:0] g;
    g = 4'b0001;
    e.is_grant = 1'b1; e.grant = g << ch; e.dur = dur;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    request = 1'b0;
    chk({name, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run(input vec_t v);
    logic m;
    m = (v.ut == v.tok);
    if (m) push_grant(v.ch, int'(v.t)); else push_err();
    system_token = v.tok; ch_sel = v.ch; time_data = v.t; request = 1'b1;
    tick();
    request = 1'b0;
    chk("auth_busy", {31'd0, busy}, 32'd1);
    user_token = v.ut; confirm = 1'b1;
    tick();
    confirm = 1'b0;
    if (m) begin
      model_fail = 0;
      request = 1'b1;
      ch_sel = v.ch + 2'd1;
    end else begin
      model_fail++;
    end
    wait_idle("session", 400);
    chk("fail_cnt", fail_cnt, model_fail);
  endtask

  initial begin
    int n;
    vec[0] = '{tok: 3'b001, ch: 2'd0, t: 8'h0F, ut: 3'b001};
    vec[1] = '{tok: 3'b011, ch: 2'd2, t: 8'h0B, ut: 3'b011};
    vec[2] = '{tok: 3'b101, ch: 2'd1, t: 8'h01, ut: 3'b101};
    vec[3] = '{tok: 3'b110, ch: 2'd3, t: 8'hFF, ut: 3'b110};
    vec[4] = '{tok: 3'b001, ch: 2'd0, t: 8'h03, ut: 3'b111};
    vec[5] = '{tok: 3'b010, ch: 2'd1, t: 8'h04, ut: 3'b000};
    vec[6] = '{tok: 3'b100, ch: 2'd3, t: 8'h02, ut: 3'b100};

    rst_n = 1'b0;
    tick(3);
    chk("rst_grant", grant, 0);
    chk("rst_data_q", data_q, 0);
    chk("rst_data_p", data_p, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_locked", {31'd0, locked}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_fail_cnt", fail_cnt, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run(vec[i]);

    // Confirm coincident with request must not authenticate.
    push_grant(2'd1, 2);
    system_token = 3'b101; ch_sel = 2'd1; time_data = 8'd2; user_token = 3'b101;
    request = 1'b1; confirm = 1'b1;
    tick();
    request = 1'b0;
    chk("same_cycle_busy", {31'd0, busy}, 1);
    chk("same_cycle_no_grant", grant, 0);
    tick();
    confirm = 1'b0;
    chk("late_confirm_grant", grant, 4'b0010);
    wait_idle("same_cycle", 20);

    // Three consecutive mismatches lead to lockout.
    run('{tok: 3'b001, ch: 2'd0, t: 8'h05, ut: 3'b111});
    run('{tok: 3'b001, ch: 2'd0, t: 8'h05, ut: 3'b111});
    push_err();
    system_token = 3'b001; time_data = 8'h05; request = 1'b1;
    tick();
    request = 1'b0;
    user_token = 3'b111; confirm = 1'b1;
    tick();
    confirm = 1'b0;
    chk("lock_entry_locked", {31'd0, locked}, 1);
    chk("lock_fail_cnt", fail_cnt, 3);
    system_token = 3'b001; user_token = 3'b001; request = 1'b1;
    n = 0;
    while (locked && n < 100) begin
      n++;
      tick();
    end
    request = 1'b0;
    chk("lock_duration", n, 16);
    chk("lock_exit_fail_cnt", fail_cnt, 0);
    chk("lock_exit_busy", {31'd0, busy}, 0);
    model_fail = 0;
    tick();

    // Confirm timeout.
    push_err();
    system_token = 3'b010; ch_sel = 2'd1; time_data = 8'h07; request = 1'b1;
    tick();
    request = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    chk("timeout_cycles", n, 32);
    chk("timeout_fail_cnt", fail_cnt, 0);

    // Zero duration request is rejected without entering AUTH.
    push_err();
    time_data = 8'h00; request = 1'b1;
    tick();
    request = 1'b0;
    chk("zero_time_busy", {31'd0, busy}, 0);
    tick();

    // Reset in the middle of a grant.
    push_grant(2'd0, 15);
    system_token = 3'b001; ch_sel = 2'd0; time_data = 8'h0F; request = 1'b1;
    tick();
    request = 1'b0;
    user_token = 3'b001; confirm = 1'b1;
    tick();
    confirm = 1'b0;
    tick(4);
    chk("pre_reset_data_q", data_q, 11);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_data_q", data_q, 0);
    chk("mid_rst_data_p", data_p, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    push_err();
    rst_n = 1'b1; system_token = 3'b010; time_data = 8'h09; request = 1'b1;
    tick();
    request = 1'b0;
    chk("post_rst_busy", {31'd0, busy}, 1);
    tick(5);
    chk("post_rst_no_grant", grant, 0);
    wait_idle("post_rst", 40);

    tick(3);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
